alu_result_serializer: RTL

//  Downstream stage of the ALU: consumes the 16-bit registered result and its one-cycle

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_result_serializer_if.sv | 29 ++
 rtl/alu_hold_reg.sv | 26 ++
 rtl/alu_result_serializer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, widths and the result serializer state enum.
package alu_pkg;

  localparam int ALU_DATA_W = 16;
  localparam int ALU_BYTE_W = 8;
  localparam int ALU_FUN_W  = 4;

  localparam logic [3:0] FUN_ADD    = 4'h0;
  localparam logic [3:0] FUN_SUB    = 4'h1;
  localparam logic [3:0] FUN_MUL    = 4'h2;
  localparam logic [3:0] FUN_DIV    = 4'h3;
  localparam logic [3:0] FUN_AND    = 4'h4;
  localparam logic [3:0] FUN_OR     = 4'h5;
  localparam logic [3:0] FUN_NAND   = 4'h6;
  localparam logic [3:0] FUN_NOR    = 4'h7;
  localparam logic [3:0] FUN_XOR    = 4'h8;
  localparam logic [3:0] FUN_XNOR   = 4'h9;
  localparam logic [3:0] FUN_CMP_EQ = 4'hA;
  localparam logic [3:0] FUN_CMP_GT = 4'hB;
  localparam logic [3:0] FUN_CMP_LT = 4'hC;
  localparam logic [3:0] FUN_SHR    = 4'hD;
  localparam logic [3:0] FUN_SHL    = 4'hE;
  localparam logic [3:0] FUN_NOP    = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_B0 = 2'd1,
    SEND_B1 = 2'd2,
    SEND_ST = 2'd3
  } ser_state_t;

  // Status byte layout: opcode in the high nibble, dropped-result count in the low nibble.
  function automatic logic [7:0] status_byte(input logic [3:0] fun, input logic [3:0] cnt);
    return {fun, cnt};
  endfunction

endpackage

// File: rtl/alu_result_serializer_if.sv
// Bus between the ALU result stage, the serializer and the TX FIFO write port.
interface alu_result_serializer_if #(
  parameter int DATA_W = 16,
  parameter int BYTE_W = 8
);

  logic [DATA_W-1:0] ALU_OUT;
  logic              OUT_VALID;
  logic [3:0]        ALU_FUN;
  logic              FIFO_FULL;
  logic [BYTE_W-1:0] WR_DATA;
  logic              WR_INC;
  logic              BUSY;
  logic              OVERRUN;

  // Handshake: OUT_VALID is a one-cycle strobe with no ready (results never stall the ALU);
  // a byte transfers in every cycle WR_INC is high, and WR_INC is never high while
  // FIFO_FULL is high, so FIFO_FULL acts as an inverted ready on the write side.
  modport master (
    output ALU_OUT, OUT_VALID, ALU_FUN, FIFO_FULL,
    input  WR_DATA, WR_INC, BUSY, OVERRUN
  );

  modport slave (
    input  ALU_OUT, OUT_VALID, ALU_FUN, FIFO_FULL,
    output WR_DATA, WR_INC, BUSY, OVERRUN
  );

endinterface

// File: rtl/alu_hold_reg.sv
// Single-entry holding buffer; a simultaneous load and drain replaces the entry and stays valid.
module alu_hold_reg #(
  parameter int W = 20
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid
);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_result_serializer.sv
// Writes each ALU result to the TX FIFO as bytes, with a one-entry holding buffer.
// Optional ALU_STATUS_BYTE_EN appends a {ALU_FUN, drop count} status byte per result.
module alu_result_serializer
  import alu_pkg::*;
#(
  parameter int DATA_W    = ALU_DATA_W,
  parameter int BYTE_W    = ALU_BYTE_W,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RST,
  alu_result_serializer_if.slave  bus,
  output ser_state_t              dbg_state
);

`ifdef ALU_STATUS_BYTE_EN
  localparam int         ENTRY_W = DATA_W + ALU_FUN_W;
  localparam ser_state_t LAST_ST = SEND_ST;
`else
  localparam int         ENTRY_W = DATA_W;
  localparam ser_state_t LAST_ST = SEND_B1;
`endif

  ser_state_t         state_q;
  logic [ENTRY_W-1:0] work_q;
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] hold_dout;
  logic               hold_valid;
  logic               hold_load;
  logic               hold_drain;
  logic               overrun_q;
  logic               idle;
  logic               wr_en;
  logic               last_wr;
  logic               take_direct;
  logic               drop;
  logic [DATA_W-1:0]  work_data;
  logic [BYTE_W-1:0]  lo_byte;
  logic [BYTE_W-1:0]  hi_byte;
  logic [BYTE_W-1:0]  wr_byte;

`ifdef ALU_STATUS_BYTE_EN
  logic [3:0] drop_cnt_q;
  logic       st_wr;
  assign in_entry = {bus.ALU_OUT, bus.ALU_FUN};
  assign st_wr    = wr_en & (state_q == SEND_ST);
`else
  logic unused_fun;
  assign in_entry   = bus.ALU_OUT;
  assign unused_fun = ^bus.ALU_FUN;
`endif

  assign work_data = work_q[ENTRY_W-1 -: DATA_W];
  assign lo_byte   = work_data[BYTE_W-1:0];
  assign hi_byte   = work_data[DATA_W-1:BYTE_W];

  assign idle    = (state_q == IDLE);
  assign wr_en   = !idle && !bus.FIFO_FULL;
  assign last_wr = wr_en && (state_q == LAST_ST);

  // A result bypasses the holding reg when the working reg is free now or frees this cycle
  // with nothing queued; otherwise it queues, and is dropped only if the queue stays full.
  assign take_direct = bus.OUT_VALID && (idle || (last_wr && !hold_valid));
  assign hold_drain  = last_wr && hold_valid;
  assign hold_load   = bus.OUT_VALID && !take_direct && (!hold_valid || hold_drain);
  assign drop        = bus.OUT_VALID && !take_direct && hold_valid && !hold_drain;

  always_comb begin
    wr_byte = '0;
    case (state_q)
      SEND_B0: wr_byte = LSB_FIRST ? lo_byte : hi_byte;
      SEND_B1: wr_byte = LSB_FIRST ? hi_byte : lo_byte;
`ifdef ALU_STATUS_BYTE_EN
      SEND_ST: wr_byte = BYTE_W'(status_byte(work_q[ALU_FUN_W-1:0], drop_cnt_q));
`endif
      default: wr_byte = '0;
    endcase
  end

  alu_hold_reg #(.W(ENTRY_W)) u_hold (
    .CLK   (CLK),
    .RST   (RST),
    .load  (hold_load),
    .drain (hold_drain),
    .din   (in_entry),
    .dout  (hold_dout),
    .valid (hold_valid)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      work_q    <= '0;
      overrun_q <= 1'b0;
`ifdef ALU_STATUS_BYTE_EN
      drop_cnt_q <= 4'h0;
`endif
    end else begin
      overrun_q <= drop;
      if (take_direct) begin
        work_q  <= in_entry;
        state_q <= SEND_B0;
      end else if (hold_drain) begin
        work_q  <= hold_dout;
        state_q <= SEND_B0;
      end else if (wr_en) begin
        case (state_q)
          SEND_B0: state_q <= SEND_B1;
`ifdef ALU_STATUS_BYTE_EN
          SEND_B1: state_q <= SEND_ST;
`else
          SEND_B1: state_q <= IDLE;
`endif
          default: state_q <= IDLE;
        endcase
      end
`ifdef ALU_STATUS_BYTE_EN
      // The count restarts when reported; a drop in the reporting cycle is the first new one.
      if (st_wr) begin
        drop_cnt_q <= drop ? 4'h1 : 4'h0;
      end else if (drop && (drop_cnt_q != 4'hF)) begin
        drop_cnt_q <= drop_cnt_q + 4'h1;
      end
`endif
    end
  end

  assign bus.WR_DATA = wr_byte;
  assign bus.WR_INC  = wr_en;
  assign bus.BUSY    = !idle || hold_valid;
  assign bus.OVERRUN = overrun_q;
  assign dbg_state   = state_q;

endmodule
